sdmp3_stream_checker: RTL
=========================

Name: sdmp3_stream_checker

Overview:
- Synthesizable scoreboard for SD-to-MP3 streaming tests. Passively samples two serial links, each with its own serial clock sampled in the system clock domain.
- Source link: SD card data out. Sink link: MP3 decoder data in.
- Deserialises each link into WIDTH-bit words and queues source words in a DEPTH-entry FIFO. Each sink word is compared in order against the FIFO head.
- Generalises the single fixed byte-FIFO check to parametrised word width, depth and per-link bit order, with sticky diagnostics and counters.

Parameters:
- WIDTH, 8, word width in bits (2..32).
- DEPTH, 16, FIFO entries; power of two, >=2.
- SRC_MSB_FIRST, 1, source bit order: 1 = MSB first, 0 = LSB first.
- SNK_MSB_FIRST, 1, sink bit order: same encoding.
- CNT_W, 16, width of the match and error counters.

Ports:
- clk  in  1  system clock, must be at least 4x either serial clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of sticky flags, counters and FIFO; bit counters unaffected.
- src_clk  in  1  source serial clock (async).
- src_dat  in  1  source serial data.
- src_en  in  1  source framing; low holds the source bit counter at 0.
- snk_clk  in  1  sink serial clock (async).
- snk_dat  in  1  sink serial data.
- snk_en  in  1  sink framing; low holds the sink bit counter at 0.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- match_cnt  out  CNT_W  compared-equal words, saturating.
- err_cnt  out  CNT_W  mismatches, saturating.
- mismatch  out  1  sticky: at least one compare failed.
- first_exp  out  WIDTH  expected word at the first mismatch.
- first_act  out  WIDTH  actual word at the first mismatch.
- overflow  out  1  sticky: source word dropped because the FIFO was full.
- underflow  out  1  sticky: sink word arrived with nothing to compare against.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FIFO empty, both bit counters 0, synchroniser flops 0. rst takes priority over clr.
- Input sampling:
  - Each *_clk, *_dat and *_en passes through a 2-flop synchroniser.
  - A rising edge is detected when the synchronised clock is 1 and its previous value was 0.
  - On that cycle the synchronised data bit is shifted in, only if the synchronised en is 1.
- Deserialiser:
  - MSB-first: shift left, new bit in at bit 0.
  - LSB-first: shift right, new bit in at bit WIDTH-1.
  - The bit counter wraps WIDTH-1 -> 0 and asserts a one-cycle word_valid on the cycle after the WIDTH-th bit.
  - Synchronised en low clears the counter; a partial word is discarded silently.
- Push (src word_valid): if not full, write the word and increment level. If full and no simultaneous pop: drop the word and set overflow. If full with a simultaneous pop: both occur and level is unchanged.
- Compare (snk word_valid):
  - level>0: pop the head and compare. Equal: match_cnt+1. Unequal: err_cnt+1 and set mismatch. If mismatch was previously 0, latch first_exp/first_act.
  - level==0 with a simultaneous push: bypass. Compare against the word being pushed, which is not stored; level stays 0.
  - level==0 and no push: set underflow; no counter changes.
- Latency:
  - Serial edge to word_valid: 3 clk (2 sync + 1 register).
  - word_valid to counter/flag update: 1 clk.
  - word_valid to level update: 1 clk.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr:
  - Zeroes counters, flags, first_exp/first_act and FIFO pointers on the next edge.
  - Push/compare events in the same cycle as clr are discarded.
- FIFO:
  - Read/write pointers are $clog2(DEPTH)+1 bits; full/empty are derived from pointer compare.
  - Pointers wrap naturally modulo 2*DEPTH.

Test Plan:
- Source bytes 0x12,0x34,0x56 MSB-first, then identical sink bytes, serial clocks at clk/8 -> match_cnt=3, err_cnt=0, level 3 then 0, all flags 0.
- Source 0xA5, sink 0xA4 -> mismatch=1, err_cnt=1, first_exp=0xA5, first_act=0xA4. Then source 0x01/sink 0x02 -> err_cnt=2, first_* unchanged.
- 17 source bytes with DEPTH=16 and no sink -> level=16, overflow=1. Then 16 matching sink bytes (values 0..15) -> match_cnt=16, level=0.
- Sink byte 0x77 with FIFO empty and no source -> underflow=1, counters 0. Separately, source and sink 0x77 completing on the same clk with FIFO empty -> match_cnt=1, level stays 0, underflow=0.
- WIDTH=16, SRC_MSB_FIRST=0, SNK_MSB_FIRST=0, word 0xBEEF sent LSB-first on both links; src_en dropped after 5 bits of a second word -> match_cnt=1, partial word discarded, level=0.
- Mid-stream: level=4 and mismatch=1, then pulse clr for 1 clk -> all counters/flags 0, level 0. Same state, then rst for 1 clk -> identical zero state, bit counters 0.

Source files
------------

// File: rtl/sdmp3_stream_checker.sv
// Passive in-order scoreboard: deserialises a source and a sink serial link in the
// system clock domain and checks every sink word against a FIFO of source words.
module sdmp3_stream_checker_deser #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_clk,
    input  logic             ser_dat,
    input  logic             ser_en,
    output logic             word_valid,
    output logic [WIDTH-1:0] word
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2:0]       sync1_q, sync2_q;
    logic             clk_prev_q;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             clk_s, dat_s, en_s, rise;

    assign {clk_s, dat_s, en_s} = sync2_q;
    assign rise = clk_s & ~clk_prev_q;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        vld_d = 1'b0;
        if (!en_s) begin
            cnt_d = '0;
        end else if (rise) begin
            if (MSB_FIRST != 0) sh_d = {sh_q[WIDTH-2:0], dat_s};
            else                sh_d = {dat_s, sh_q[WIDTH-1:1]};
            if (cnt_q == LAST) begin
                cnt_d = '0;
                vld_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            clk_prev_q <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            sync1_q    <= {ser_clk, ser_dat, ser_en};
            sync2_q    <= sync1_q;
            clk_prev_q <= clk_s;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
        end
    end

    // The shifter only moves on a serial edge, several clk after word_valid, so it doubles as the word register.
    assign word_valid = vld_q;
    assign word       = sh_q;
endmodule

module sdmp3_stream_checker #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int SRC_MSB_FIRST = 1,
    parameter int SNK_MSB_FIRST = 1,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     src_clk,
    input  logic                     src_dat,
    input  logic                     src_en,
    input  logic                     snk_clk,
    input  logic                     snk_dat,
    input  logic                     snk_en,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     mismatch,
    output logic [WIDTH-1:0]         first_exp,
    output logic [WIDTH-1:0]         first_act,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic             src_vld, snk_vld;
    logic [WIDTH-1:0] src_word, snk_word;

    sdmp3_stream_checker_deser #(.WIDTH(WIDTH), .MSB_FIRST(SRC_MSB_FIRST)) u_src (
        .clk(clk), .rst(rst), .ser_clk(src_clk), .ser_dat(src_dat), .ser_en(src_en),
        .word_valid(src_vld), .word(src_word)
    );

    sdmp3_stream_checker_deser #(.WIDTH(WIDTH), .MSB_FIRST(SNK_MSB_FIRST)) u_snk (
        .clk(clk), .rst(rst), .ser_clk(snk_clk), .ser_dat(snk_dat), .ser_en(snk_en),
        .word_valid(snk_vld), .word(snk_word)
    );

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d, err_cnt_q, err_cnt_d;
    logic             mismatch_q, mismatch_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d, first_act_q, first_act_d;

    logic             empty, full, push, pop, cmp, bypass;
    logic [WIDTH-1:0] head, exp_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        mismatch_d  = mismatch_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        push        = 1'b0;
        pop         = 1'b0;
        cmp         = 1'b0;
        bypass      = 1'b0;
        exp_word    = head;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            match_cnt_d = '0;
            err_cnt_d   = '0;
            mismatch_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            first_exp_d = '0;
            first_act_d = '0;
        end else begin
            if (snk_vld) begin
                if (!empty) begin
                    pop = 1'b1;
                    cmp = 1'b1;
                end else if (src_vld) begin
                    bypass   = 1'b1;
                    cmp      = 1'b1;
                    exp_word = src_word;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            // A full FIFO still accepts a push when the head leaves in the same cycle.
            if (src_vld && !bypass) begin
                if (!full || pop) push = 1'b1;
                else              overflow_d = 1'b1;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (cmp) begin
                if (exp_word == snk_word) begin
                    if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
                end else begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    mismatch_d = 1'b1;
                    if (!mismatch_q) begin
                        first_exp_d = exp_word;
                        first_act_d = snk_word;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= src_word;
    end

    assign level     = wr_ptr_q - rd_ptr_q;
    assign match_cnt = match_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign mismatch  = mismatch_q;
    assign first_exp = first_exp_q;
    assign first_act = first_act_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule
